// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
//
// Purpose: inverse of the immediate extender. Given a 32-bit constant or
// byte offset and an immSrc selector, produce the packed instruction
// immediate field that the extender expands back to the same value, and
// flag when no encoding exists.
//   immSrc 00 : data-processing rotated imm8 (searched, one rotation/cycle)
//   immSrc 01 : LDR/STR 12-bit unsigned offset
//   immSrc 10 : branch 24-bit signed word offset
//   immSrc 11 : reserved, never encodable
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous active-high reset
//   start   in   1   request strobe, only honoured in IDLE
//   immSrc  in   2   immediate format selector, captured on accept
//   value   in  32   value to encode, captured on accept
//   busy    out  1   high while a request is in SEARCH or DONE
//   done    out  1   one-cycle pulse, ok/field valid in that cycle
//   ok      out  1   1 = encoding found
//   field   out 24   packed immediate, held until the next DONE entry
// ---------------------------------------------------------------------------
module imm_encoder #(
    parameter int ROT_STEPS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  immSrc,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [23:0] field
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROT = 4'(ROT_STEPS - 1);

    state_t      r_state;
    logic [31:0] r_value;
    logic [3:0]  r_rot;
    logic        r_busy;
    logic        r_done;
    logic        r_ok;
    logic [23:0] r_field;

    logic [4:0]  w_shamt;
    logic [31:0] w_cand;
    logic        w_hit;
    logic [24:0] w_direct;

    // Non-searched formats resolve in one step: returns {ok, field}.
    // A failing encode always yields a zero field.
    function automatic logic [24:0] f_direct(input logic [1:0]  src,
                                             input logic [31:0] v);
        logic [24:0] res;
        res = 25'd0;
        case (src)
            2'b01: begin
                if (v[31:12] == 20'd0)
                    res = {1'b1, 12'd0, v[11:0]};
            end
            2'b10: begin
                // Word aligned and bits 31:26 are copies of the sign bit 25,
                // so sign-extending {field, 2'b00} reproduces v exactly.
                if ((v[1:0] == 2'b00) &&
                    ((v[31:25] == 7'h00) || (v[31:25] == 7'h7F)))
                    res = {1'b1, v[25:2]};
            end
            default: res = 25'd0;
        endcase
        return res;
    endfunction

    // Candidate for the current rotation: value rotated left by 2*rot.
    // At rot=0 the right shift amount is 32, which yields zero, so the
    // OR degenerates to the plain value.
    assign w_shamt  = {r_rot, 1'b0};
    assign w_cand   = (r_value << w_shamt) | (r_value >> (6'd32 - {1'b0, w_shamt}));
    assign w_hit    = (w_cand[31:8] == 24'd0);
    assign w_direct = f_direct(immSrc, value);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_value <= 32'd0;
            r_rot   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_field <= 24'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_value <= value;
                        r_rot   <= 4'd0;
                        r_busy  <= 1'b1;
                        if (immSrc == 2'b00) begin
                            r_state <= S_SEARCH;
                        end else begin
                            r_ok    <= w_direct[24];
                            r_field <= w_direct[23:0];
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SEARCH: begin
                    // Rotations are tried in increasing order, so the first
                    // hit is the smallest rotation that works.
                    if (w_hit) begin
                        r_ok    <= 1'b1;
                        r_field <= {12'd0, r_rot, w_cand[7:0]};
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_rot == LAST_ROT) begin
                        r_ok    <= 1'b0;
                        r_field <= 24'd0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_rot <= r_rot + 4'd1;
                    end
                end
                S_DONE: begin
                    // start is deliberately ignored here; the next request
                    // can only be taken once back in IDLE.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign ok    = r_ok;
    assign field = r_field;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  immSrc;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        ok;
    logic [23:0] field;

    int checks = 0;
    int errors = 0;

    imm_encoder #(.ROT_STEPS(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .immSrc (immSrc),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .ok     (ok),
        .field  (field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference encoding rules ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (32 - n));
    endfunction

    // Smallest rotation k such that rotl(v, 2k) fits in 8 bits, else -1.
    function automatic int dp_rot(input logic [31:0] v);
        for (int k = 0; k < 16; k++)
            if (rotl(v, 2 * k) < 32'd256) return k;
        return -1;
    endfunction

    function automatic logic br_ok(input logic [31:0] v);
        logic [31:0] ext;
        ext = {{6{v[25]}}, v[25:0]};
        return (ext == v) && (v[1:0] == 2'b00);
    endfunction

    function automatic logic enc_ok(input logic [31:0] v, input logic [1:0] s);
        case (s)
            2'b00:   return dp_rot(v) >= 0;
            2'b01:   return v < 32'h1000;
            2'b10:   return br_ok(v);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [23:0] enc_field(input logic [31:0] v, input logic [1:0] s);
        int          k;
        logic [31:0] c;
        logic [3:0]  k4;
        case (s)
            2'b00: begin
                k = dp_rot(v);
                if (k < 0) return 24'd0;
                c  = rotl(v, 2 * k);
                k4 = 4'(k);
                return {12'd0, k4, c[7:0]};
            end
            2'b01:   return (v < 32'h1000) ? v[23:0] : 24'd0;
            2'b10:   return br_ok(v) ? v[25:2] : 24'd0;
            default: return 24'd0;
        endcase
    endfunction

    function automatic int enc_lat(input logic [31:0] v, input logic [1:0] s);
        int k;
        if (s != 2'b00) return 1;
        k = dp_rot(v);
        return (k < 0) ? 17 : k + 2;
    endfunction

    // ---------------- cycle model: latency countdown ----------------
    logic        exp_busy, exp_done, exp_ok;
    logic [23:0] exp_field, pend_field;
    logic        pend_ok;
    int          m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_busy  <= 1'b0;
            exp_done  <= 1'b0;
            exp_ok    <= 1'b0;
            exp_field <= 24'd0;
            pend_ok   <= 1'b0;
            pend_field<= 24'd0;
            m_cnt     <= 0;
        end else if (exp_done) begin
            exp_done <= 1'b0;
            exp_busy <= 1'b0;
        end else if (exp_busy) begin
            if (m_cnt == 1) begin
                exp_done  <= 1'b1;
                exp_ok    <= pend_ok;
                exp_field <= pend_field;
            end
            m_cnt <= m_cnt - 1;
        end else if (start) begin
            exp_busy <= 1'b1;
            if (enc_lat(value, immSrc) == 1) begin
                exp_done  <= 1'b1;
                exp_ok    <= enc_ok(value, immSrc);
                exp_field <= enc_field(value, immSrc);
            end else begin
                pend_ok    <= enc_ok(value, immSrc);
                pend_field <= enc_field(value, immSrc);
                m_cnt      <= enc_lat(value, immSrc) - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy",  32'(busy),  32'(exp_busy));
        chk("done",  32'(done),  32'(exp_done));
        chk("ok",    32'(ok),    32'(exp_ok));
        chk("field", 32'(field), 32'(exp_field));
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n = 0;
        while (exp_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: request still busy after %0d cycles", n);
        end
    endtask

    // Issue one request, scramble inputs after acceptance, optionally
    // pulse start while busy (must be ignored), then wait for completion.
    task automatic req(input logic [31:0] v, input logic [1:0] s, input bit noise);
        int n;
        wait_idle();
        @(negedge clk);
        #1;
        start  = 1'b1;
        value  = v;
        immSrc = s;
        @(posedge clk);
        #1;
        start  = 1'b0;
        value  = $urandom;
        immSrc = 2'($urandom_range(0, 3));
        n = 0;
        while (exp_busy && n < 40) begin
            @(negedge clk);
            #1;
            start = (noise && exp_busy && !exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            n++;
        end
        start = 1'b0;
        if (exp_busy) begin
            checks++;
            errors++;
            $display("FAIL req: no completion within %0d cycles", n);
        end
    endtask

    function automatic logic [31:0] rand_value(input logic [1:0] s);
        logic [31:0] v;
        case ($urandom_range(0, 2))
            0: v = $urandom;
            1: begin
                if (s == 2'b00)
                    v = rotl(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                else if (s == 2'b10) begin
                    v = $urandom;
                    v = {{6{v[25]}}, v[25:2], 2'b00};
                end else
                    v = 32'($urandom_range(0, 16'h1FFF));
            end
            default: v = 32'($urandom_range(0, 1023));
        endcase
        return v;
    endfunction

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        immSrc = 2'b00;
        value  = 32'd0;

        // Hand-computed pins for the model itself.
        chk("pin dp FF field",  32'(enc_field(32'h000000FF, 2'b00)), 32'h0000FF);
        chk("pin dp FF lat",    32'(enc_lat  (32'h000000FF, 2'b00)), 32'd2);
        chk("pin dp 3F0 field", 32'(enc_field(32'h000003F0, 2'b00)), 32'h000E3F);
        chk("pin dp 3F0 lat",   32'(enc_lat  (32'h000003F0, 2'b00)), 32'd16);
        chk("pin dp 101 ok",    32'(enc_ok   (32'h00000101, 2'b00)), 32'd0);
        chk("pin dp 101 lat",   32'(enc_lat  (32'h00000101, 2'b00)), 32'd17);
        chk("pin br FFFFFFFC",  32'(enc_field(32'hFFFFFFFC, 2'b10)), 32'hFFFFFF);
        chk("pin br 01FFFFFC",  32'(enc_field(32'h01FFFFFC, 2'b10)), 32'h7FFFFF);
        chk("pin br 02000000",  32'(enc_ok   (32'h02000000, 2'b10)), 32'd0);
        chk("pin br 00000006",  32'(enc_ok   (32'h00000006, 2'b10)), 32'd0);
        chk("pin ls FFF",       32'(enc_field(32'h00000FFF, 2'b01)), 32'h000FFF);
        chk("pin ls 1000",      32'(enc_ok   (32'h00001000, 2'b01)), 32'd0);
        chk("pin rsv",          32'(enc_ok   (32'h00000000, 2'b11)), 32'd0);

        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // Directed cases; the compare process checks every cycle.
        req(32'h000000FF, 2'b00, 1'b0);
        req(32'h000003F0, 2'b00, 1'b0);
        req(32'h00000101, 2'b00, 1'b1);
        req(32'hFFFFFFFC, 2'b10, 1'b0);
        req(32'h01FFFFFC, 2'b10, 1'b0);
        req(32'h02000000, 2'b10, 1'b0);
        req(32'h00000006, 2'b10, 1'b0);
        req(32'h00000FFF, 2'b01, 1'b0);
        req(32'h00001000, 2'b01, 1'b0);
        req(32'h12345678, 2'b11, 1'b0);
        req(32'h00000FFF, 2'b01, 1'b0);

        // Asynchronous reset mid-search: outputs clear before the next edge.
        wait_idle();
        @(negedge clk);
        #1;
        start  = 1'b1;
        value  = 32'h00000101;
        immSrc = 2'b00;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst busy",  32'(busy),  32'd0);
        chk("rst done",  32'(done),  32'd0);
        chk("rst ok",    32'(ok),    32'd0);
        chk("rst field", 32'(field), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        req(32'h0000FF00, 2'b00, 1'b0);

        // start held high: back-to-back acceptance with changing inputs.
        wait_idle();
        @(negedge clk);
        #1 start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            immSrc = 2'($urandom_range(0, 3));
            value  = rand_value(immSrc);
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();

        // Randomized requests.
        for (int i = 0; i < 250; i++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            req(rand_value(s), s, 1'($urandom_range(0, 1)));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
